digit_entry: RTL and testbench

Switch/pushbutton front end that turns Basys 3 user input into a 16-bit binary operand and hands it to the CPU over a valid/ready handshake. It is the input-side counterpart of the display path: the operator keys decimal digits on the switches, the running value is exposed for the seven-segment display, and a commit press offers the finished value to the processor.

---
 rtl/digit_entry_pkg.sv | 26 ++
 rtl/digit_entry_debouncer.sv | 57 +++++
 rtl/digit_entry.sv | 143 ++++++++++++++
 tb/tb_digit_entry.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/digit_entry_pkg.sv
// digit_entry_pkg
// Shared types, limits and helpers for the digit_entry front end.
//   state_t                  : FSM states (ENTRY collects digits, OFFER holds a committed value)
//   MAX_DIGITS               : most decimal digits one entry may hold
//   MAX_VALUE                : largest representable operand
//   DEFAULT_DEBOUNCE_CYCLES  : 10 ms of stable samples at 100 MHz
//   mul10_add()              : v*10 + d evaluated 20 bits wide so overflow is visible
package digit_entry_pkg;

    typedef enum logic [0:0] {
        ENTRY = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam int          MAX_DIGITS              = 5;
    localparam logic [15:0] MAX_VALUE               = 16'hFFFF;
    localparam int          DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

    // Multiply-by-ten as two shifts and an add; the 20-bit result exposes any carry past 16 bits.
    function automatic logic [19:0] mul10_add(input logic [15:0] v, input logic [3:0] d);
        logic [19:0] w;
        w = {4'h0, v};
        return (w << 3) + (w << 1) + {16'h0000, d};
    endfunction

endpackage

// File: rtl/digit_entry_debouncer.sv
// digit_entry_debouncer
// Synchronizes one raw pushbutton, accepts a new level only after DEBOUNCE_CYCLES
// consecutive identical synchronized samples, and emits a one-cycle pulse when the
// accepted level rises.
//   clk   : system clock
//   rst   : asynchronous active-high reset, accepted level reads 0
//   raw   : asynchronous button input
//   rise  : registered one-cycle pulse on a debounced rising edge
module digit_entry_debouncer #(
    parameter int DEBOUNCE_CYCLES = digit_entry_pkg::DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             rise_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronizer, stability counter, accepted level and rising-edge pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            rise_r  <= 1'b0;
            if (sync2_r != level_r) begin
                // The sample being consumed now is the DEBOUNCE_CYCLES-th differing one.
                if (cnt_r == LAST_CNT) begin
                    level_r <= sync2_r;
                    rise_r  <= sync2_r;
                    cnt_r   <= '0;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                // Any sample matching the accepted level restarts the count.
                cnt_r <= '0;
            end
        end
    end

    assign rise = rise_r;

endmodule

// File: rtl/digit_entry.sv
// digit_entry
// Builds a 16-bit operand from decimal digits keyed on the switches and offers the
// finished value to the CPU over a valid/ready handshake.
//   clock100Mhz : 100 MHz clock
//   reset       : asynchronous active-high reset
//   sw          : BCD digit from the switches (raw)
//   btnEnter    : append sw to the entry (raw button)
//   btnClear    : discard the entry (raw button)
//   btnCommit   : offer the entry to the CPU (raw button)
//   entryValue  : running binary value for the display
//   digitCount  : digits accepted so far (0..5)
//   dataOut     : committed operand, stable while dataValid is high
//   dataValid   : dataOut is offered
//   dataReady   : CPU accepts dataOut
//   entryError  : one-cycle pulse on a rejected action
module digit_entry
    import digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic        clock100Mhz,
    input  logic        reset,
    input  logic [3:0]  sw,
    input  logic        btnEnter,
    input  logic        btnClear,
    input  logic        btnCommit,
    output logic [15:0] entryValue,
    output logic [2:0]  digitCount,
    output logic [15:0] dataOut,
    output logic        dataValid,
    input  logic        dataReady,
    output logic        entryError
);

    state_t      state_r, state_s;
    logic [3:0]  sw_sync1_r, sw_sync2_r;
    logic [15:0] value_r, value_s;
    logic [2:0]  count_r, count_s;
    logic [15:0] out_r, out_s;
    logic        valid_r, valid_s;
    logic        err_r, err_s;
    logic        enter_s, clear_s, commit_s;
    logic [19:0] next_sum_s;

    digit_entry_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk(clock100Mhz), .rst(reset), .raw(btnEnter), .rise(enter_s)
    );
    digit_entry_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk(clock100Mhz), .rst(reset), .raw(btnClear), .rise(clear_s)
    );
    digit_entry_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_commit (
        .clk(clock100Mhz), .rst(reset), .raw(btnCommit), .rise(commit_s)
    );

    // Two-flop synchronizer for the switch digit, keeping it aligned with the button paths.
    always_ff @(posedge clock100Mhz or posedge reset) begin
        if (reset) begin
            sw_sync1_r <= 4'h0;
            sw_sync2_r <= 4'h0;
        end else begin
            sw_sync1_r <= sw;
            sw_sync2_r <= sw_sync1_r;
        end
    end

    assign next_sum_s = mul10_add(value_r, sw_sync2_r);

    // Next-state and datapath decisions; every register holds unless an action changes it.
    always_comb begin
        state_s = state_r;
        value_s = value_r;
        count_s = count_r;
        out_s   = out_r;
        valid_s = valid_r;
        err_s   = 1'b0;
        case (state_r)
            ENTRY: begin
                if (clear_s) begin
                    value_s = 16'h0000;
                    count_s = 3'd0;
                end else if (commit_s) begin
                    out_s   = value_r;
                    valid_s = 1'b1;
                    state_s = OFFER;
                end else if (enter_s) begin
                    if (sw_sync2_r > 4'd9) begin
                        err_s = 1'b1;
                    end else if ((next_sum_s > {4'h0, MAX_VALUE}) ||
                                 (count_r == 3'(MAX_DIGITS))) begin
                        err_s = 1'b1;
                    end else begin
                        value_s = next_sum_s[15:0];
                        count_s = count_r + 3'd1;
                    end
                end else begin
                    err_s = 1'b0;
                end
            end
            OFFER: begin
                // The offer is never retracted; only the CPU's acceptance ends it.
                err_s = enter_s | clear_s | commit_s;
                if (dataReady) begin
                    valid_s = 1'b0;
                    value_s = 16'h0000;
                    count_s = 3'd0;
                    state_s = ENTRY;
                end else begin
                    valid_s = 1'b1;
                end
            end
            default: begin
                state_s = ENTRY;
                valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock100Mhz or posedge reset) begin
        if (reset) begin
            state_r <= ENTRY;
            value_r <= 16'h0000;
            count_r <= 3'd0;
            out_r   <= 16'h0000;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            value_r <= value_s;
            count_r <= count_s;
            out_r   <= out_s;
            valid_r <= valid_s;
            err_r   <= err_s;
        end
    end

    assign entryValue = value_r;
    assign digitCount = count_r;
    assign dataOut    = out_r;
    assign dataValid  = valid_r;
    assign entryError = err_r;

endmodule

// File: tb/tb_digit_entry.sv
// tb_digit_entry
// Directed, table-driven bench for digit_entry with a short debounce window.
module tb_digit_entry;

    logic        clock100Mhz = 1'b0;
    logic        reset;
    logic [3:0]  sw;
    logic        btnEnter, btnClear, btnCommit, dataReady;
    logic [15:0] entryValue, dataOut;
    logic [2:0]  digitCount;
    logic        dataValid, entryError;

    digit_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clock100Mhz(clock100Mhz), .reset(reset), .sw(sw),
        .btnEnter(btnEnter), .btnClear(btnClear), .btnCommit(btnCommit),
        .entryValue(entryValue), .digitCount(digitCount),
        .dataOut(dataOut), .dataValid(dataValid), .dataReady(dataReady),
        .entryError(entryError)
    );

    always #5 clock100Mhz = ~clock100Mhz;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int valid_cycles = 0;

    // Running counts of error pulses and offered cycles, sampled away from the active edge.
    always @(negedge clock100Mhz) begin
        if (entryError === 1'b1) err_pulses++;
        if (dataValid === 1'b1) valid_cycles++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // btn bits: [0] enter, [1] clear, [2] commit
    task automatic press(input logic [3:0] d, input logic [2:0] b, input int hold);
        @(negedge clock100Mhz);
        sw        = d;
        btnEnter  = b[0];
        btnClear  = b[1];
        btnCommit = b[2];
        repeat (hold) @(negedge clock100Mhz);
        btnEnter  = 1'b0;
        btnClear  = 1'b0;
        btnCommit = 1'b0;
        repeat (12) @(negedge clock100Mhz);
    endtask

    typedef struct {
        logic [3:0]  d;
        logic [2:0]  btn;
        logic [15:0] val;
        logic [2:0]  cnt;
        int          err;
    } vec_t;

    vec_t tbl[26];

    task automatic run_rows(input int first, input int last);
        int e0;
        for (int i = first; i <= last; i++) begin
            e0 = err_pulses;
            press(tbl[i].d, tbl[i].btn, 12);
            check($sformatf("row%0d value", i), 32'(entryValue), 32'(tbl[i].val));
            check($sformatf("row%0d count", i), 32'(digitCount), 32'(tbl[i].cnt));
            check($sformatf("row%0d err", i), 32'(err_pulses - e0), 32'(tbl[i].err));
        end
    endtask

    initial begin
        int e0;
        int v0;
        int lat;

        tbl[0]  = '{4'd1, 3'b001, 16'd1,     3'd1, 0};
        tbl[1]  = '{4'd2, 3'b001, 16'd12,    3'd2, 0};
        tbl[2]  = '{4'd3, 3'b001, 16'd123,   3'd3, 0};
        tbl[3]  = '{4'd4, 3'b001, 16'd1234,  3'd4, 0};
        tbl[4]  = '{4'd5, 3'b001, 16'd12345, 3'd5, 0};
        tbl[5]  = '{4'd6, 3'b001, 16'd6,     3'd1, 0};
        tbl[6]  = '{4'd5, 3'b001, 16'd65,    3'd2, 0};
        tbl[7]  = '{4'd5, 3'b001, 16'd655,   3'd3, 0};
        tbl[8]  = '{4'd3, 3'b001, 16'd6553,  3'd4, 0};
        tbl[9]  = '{4'd5, 3'b001, 16'd65535, 3'd5, 0};
        tbl[10] = '{4'd0, 3'b010, 16'd0,     3'd0, 0};
        tbl[11] = '{4'd6, 3'b001, 16'd6,     3'd1, 0};
        tbl[12] = '{4'd5, 3'b001, 16'd65,    3'd2, 0};
        tbl[13] = '{4'd5, 3'b001, 16'd655,   3'd3, 0};
        tbl[14] = '{4'd3, 3'b001, 16'd6553,  3'd4, 0};
        tbl[15] = '{4'd6, 3'b001, 16'd6553,  3'd4, 1};
        tbl[16] = '{4'hA, 3'b001, 16'd6553,  3'd4, 1};
        tbl[17] = '{4'd0, 3'b010, 16'd0,     3'd0, 0};
        tbl[18] = '{4'd0, 3'b001, 16'd0,     3'd1, 0};
        tbl[19] = '{4'd0, 3'b001, 16'd0,     3'd2, 0};
        tbl[20] = '{4'd0, 3'b001, 16'd0,     3'd3, 0};
        tbl[21] = '{4'd0, 3'b001, 16'd0,     3'd4, 0};
        tbl[22] = '{4'd0, 3'b001, 16'd0,     3'd5, 0};
        tbl[23] = '{4'd1, 3'b001, 16'd0,     3'd5, 1};
        tbl[24] = '{4'd0, 3'b010, 16'd0,     3'd0, 0};
        tbl[25] = '{4'd9, 3'b001, 16'd9,     3'd1, 0};

        reset = 1'b1; sw = 4'h0; dataReady = 1'b0;
        btnEnter = 1'b0; btnClear = 1'b0; btnCommit = 1'b0;
        repeat (3) @(negedge clock100Mhz);
        check("rst entryValue", 32'(entryValue), 32'd0);
        check("rst digitCount", 32'(digitCount), 32'd0);
        check("rst dataOut",    32'(dataOut),    32'd0);
        check("rst dataValid",  32'(dataValid),  32'd0);
        check("rst entryError", 32'(entryError), 32'd0);
        reset = 1'b0;

        run_rows(0, 4);

        // Commit 12345 with the CPU not ready: offer must hold stable.
        press(4'd0, 3'b100, 12);
        check("offer valid", 32'(dataValid), 32'd1);
        check("offer data",  32'(dataOut),   32'd12345);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock100Mhz);
            check("offer hold valid", 32'(dataValid), 32'd1);
            check("offer hold data",  32'(dataOut),   32'd12345);
        end
        dataReady = 1'b1;
        @(negedge clock100Mhz);
        check("xfer valid", 32'(dataValid),  32'd0);
        check("xfer value", 32'(entryValue), 32'd0);
        check("xfer count", 32'(digitCount), 32'd0);
        dataReady = 1'b0;

        run_rows(5, 25);

        // A 3-cycle glitch is shorter than the debounce window.
        e0 = err_pulses;
        press(4'd2, 3'b001, 3);
        check("glitch value", 32'(entryValue), 32'd9);
        check("glitch count", 32'(digitCount), 32'd1);
        check("glitch err",   32'(err_pulses - e0), 32'd0);

        // Clear and commit in the same cycle: clear wins, nothing offered.
        v0 = valid_cycles;
        press(4'd0, 3'b110, 12);
        check("clr+cmt value", 32'(entryValue), 32'd0);
        check("clr+cmt valid", 32'(valid_cycles - v0), 32'd0);

        // Commit 42, then enter while offering.
        press(4'd4, 3'b001, 12);
        press(4'd2, 3'b001, 12);
        press(4'd0, 3'b100, 12);
        check("c42 valid", 32'(dataValid), 32'd1);
        check("c42 data",  32'(dataOut),   32'd42);
        e0 = err_pulses;
        press(4'd3, 3'b001, 12);
        check("offer enter err", 32'(err_pulses - e0), 32'd1);
        check("offer enter data", 32'(dataOut), 32'd42);
        check("offer enter valid", 32'(dataValid), 32'd1);
        check("offer enter value", 32'(entryValue), 32'd42);

        // Reset during the offer drops it.
        @(negedge clock100Mhz);
        reset = 1'b1;
        @(negedge clock100Mhz);
        check("mid rst value", 32'(entryValue), 32'd0);
        check("mid rst count", 32'(digitCount), 32'd0);
        check("mid rst data",  32'(dataOut),    32'd0);
        check("mid rst valid", 32'(dataValid),  32'd0);
        check("mid rst err",   32'(entryError), 32'd0);
        reset = 1'b0;

        // Ready held high ahead of the commit: one-cycle offer.
        dataReady = 1'b1;
        press(4'd8, 3'b001, 12);
        check("rdy entry value", 32'(entryValue), 32'd8);
        v0 = valid_cycles;
        press(4'd0, 3'b100, 12);
        check("rdy valid cycles", 32'(valid_cycles - v0), 32'd1);
        check("rdy data", 32'(dataOut), 32'd8);
        check("rdy value", 32'(entryValue), 32'd0);
        dataReady = 1'b0;

        // Hold enter 100 cycles with sw=7: one digit, and measure press latency.
        e0 = err_pulses;
        lat = 0;
        @(negedge clock100Mhz);
        sw = 4'd7;
        btnEnter = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clock100Mhz);
            if (lat == 0 && digitCount == 3'd1) lat = k;
        end
        btnEnter = 1'b0;
        repeat (12) @(negedge clock100Mhz);
        check("hold latency", 32'(lat), 32'd7);
        check("hold value", 32'(entryValue), 32'd7);
        check("hold count", 32'(digitCount), 32'd1);
        check("hold err",   32'(err_pulses - e0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
